jtag_tap_driver: RTL

//  JTAG host-side TAP driver: the initiator end of the JTAG link that the on-chip jtag block answers on.

---
 rtl/jtag_tap_driver.sv | 138 +++++++++++++
 1 files changed

// File: rtl/jtag_tap_driver.sv
// Host-side JTAG TAP driver: turns reset / IR-scan / DR-scan commands into TCK/TMS/TDI waveforms and captures TDO.
// Latency: 2*TCK_DIV clocks per TCK edge (N+5 edges DR, N+6 IR, 6 reset); empty or reserved commands respond next cycle.
// Backpressure: cmd_ready only while idle; a held cmd_valid is ignored until the current command has responded.
module jtag_tap_driver #(
    parameter int TCK_DIV = 2,
    parameter int MAX_LEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_type,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);
    localparam int PW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [5:0] LEN_MAX = 6'(MAX_LEN);

    typedef enum logic [2:0] {S_IDLE, S_RST, S_PRE, S_SHIFT, S_POST} state_t;

    state_t             state, state_nxt;
    logic [5:0]         cnt, cnt_nxt, len_q, len_sat;
    logic [PW-1:0]      ph;
    logic [MAX_LEN-1:0] dat_q, acc_q;
    logic [IW-1:0]      idx_cur, idx_nxt;
    logic               ph_end, rise, fall, accept, done, imm, upd, tms_nxt, tdi_nxt;

    assign cmd_ready = (state == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign len_sat   = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
    assign ph_end    = (ph == PW'(TCK_DIV - 1));
    assign rise      = !cmd_ready && ph_end && !tck;
    assign fall      = !cmd_ready && ph_end && tck;
    // Shift counter runs down from len-1, so bit index = len-1-cnt.
    assign idx_cur   = IW'(len_q - 6'd1 - cnt);
    assign idx_nxt   = IW'(len_q - 6'd1 - cnt_nxt);

    // Each (state, cnt) pair names one TCK edge; advancing happens at the start of every low phase.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done      = 1'b0;
        imm       = 1'b0;
        tms_nxt   = 1'b0;
        tdi_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_type == 2'b00) begin
                        state_nxt = S_RST;
                        cnt_nxt   = 6'd5;
                    end else if (cmd_type == 2'b11 || len_sat == 6'd0) begin
                        imm = 1'b1;
                    end else begin
                        state_nxt = S_PRE;
                        cnt_nxt   = (cmd_type == 2'b01) ? 6'd3 : 6'd2;
                    end
                end
            end
            default: begin
                if (fall) begin
                    if (cnt != 6'd0) begin
                        cnt_nxt = cnt - 6'd1;
                    end else if (state == S_PRE) begin
                        state_nxt = S_SHIFT;
                        cnt_nxt   = len_q - 6'd1;
                    end else if (state == S_SHIFT) begin
                        state_nxt = S_POST;
                        cnt_nxt   = 6'd1;
                    end else begin
                        state_nxt = S_IDLE;
                        done      = 1'b1;
                    end
                end
            end
        endcase
        upd = fall || (cmd_ready && state_nxt != S_IDLE);
        case (state_nxt)
            S_RST:   tms_nxt = (cnt_nxt != 6'd0);
            S_PRE:   tms_nxt = (cnt_nxt >= 6'd2);
            S_SHIFT: begin
                tms_nxt = (cnt_nxt == 6'd0);
                tdi_nxt = dat_q[idx_nxt];
            end
            S_POST:  tms_nxt = (cnt_nxt == 6'd1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 6'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph        <= '0;
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            len_q     <= 6'd0;
            dat_q     <= '0;
            acc_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= done || imm;
            if (accept) begin
                len_q <= len_sat;
                dat_q <= cmd_data;
                acc_q <= '0;
            end
            if (!cmd_ready) begin
                ph <= ph_end ? '0 : ph + PW'(1);
                if (ph_end) tck <= ~tck;
            end
            if (upd) begin
                tms <= tms_nxt;
                tdi <= tdi_nxt;
            end
            if (rise && state == S_SHIFT) acc_q[idx_cur] <= tdo;
            if (done) rsp_data <= acc_q;
            else if (imm) rsp_data <= '0;
        end
    end
endmodule
